hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline hazard scheduler for the five-stage MIPS core. Tracks the destination registers of in-flight instructions in the EX and MEM stages in an internal two-entry scoreboard. From that state it drives the ID-stage operand forwarding selects, the load-use stall (IF/ID hold, ID→EX bubble) and the taken-branch flush of the IF/ID register. It also keeps saturating stall and flush event counters for the debug display.

## Interface
Parameters:
- CNT_W, 16, width of the stall/flush event counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_wreg  in  1  ID instruction writes the register file
- id_m2reg  in  1  ID instruction is a load
- id_dest  in  5  ID destination register (rt/rd already selected)
- id_taken  in  1  branch/jump in ID resolves taken this cycle
- cnt_clr  in  1  synchronous clear of both counters
- hz_stall  out  1  hold PC and IF/ID, insert bubble into EX
- hz_flush  out  1  replace IF/ID contents with a NOP next edge
- hz_fwda  out  2  rs operand select: 0 regfile, 1 ex_aluR, 2 mem_aluR, 3 mem_mdata
- hz_fwdb  out  2  rt operand select, same encoding
- stall_cnt  out  CNT_W  cycles with hz_stall=1, saturating
- flush_cnt  out  CNT_W  cycles with hz_flush=1, saturating

## Operation
- Scoreboard: two registered slots, EX and MEM. Each slot holds {valid, dest[4:0], m2reg}. A slot with dest=0 or wreg=0 is stored as valid=0, so it never matches.
- Slot update every clk edge:
  - EX ← {id_wreg & (id_dest≠0), id_dest, id_m2reg} when hz_stall=0.
  - EX ← bubble (valid=0) when hz_stall=1.
  - MEM ← EX unconditionally.
  - WB is not tracked. The register file is write-first, so WB results reach the ID read ports in the same cycle.
- Match for source s (s∈{rs,rt}, gated by id_use_s, s≠0):
  - mEX = EX.valid & EX.dest==s
  - mMEM = MEM.valid & MEM.dest==s
- Forward select, with EX taking priority over MEM (youngest producer wins):
  - mEX & !EX.m2reg → 1
  - else mMEM & !MEM.m2reg → 2
  - else mMEM & MEM.m2reg → 3
  - else → 0
- Load-use stall: hz_stall = (mEX_rs & EX.m2reg) | (mEX_rt & EX.m2reg). When stalled, forward selects are don't-care, and the block drives 0.
- Flush: hz_flush = id_taken & !hz_stall. A branch waiting on a load is not resolved until the stall clears.
- hz_stall, hz_flush and hz_fwda/hz_fwdb are combinational from the slots and the ID inputs. There are no registered outputs other than the counters.
- Counters:
  - stall_cnt increments on each edge with hz_stall=1; flush_cnt increments on each edge with hz_flush=1.
  - Both hold at 2^CNT_W−1.
  - cnt_clr=1 zeroes both counters and has priority over increment.

## Timing
- Reset: all slots valid=0 and stall_cnt=flush_cnt=0. With idle ID inputs this gives hz_stall=0, hz_flush=0 and hz_fwda=hz_fwdb=0.
- Forward/stall decisions have zero latency: they are valid in the same cycle the ID inputs are valid.
- A load followed immediately by a dependent instruction stalls exactly 1 cycle. On the next cycle the load sits in MEM and the select becomes 3.
- Load followed by a dependent instruction two slots later: no stall, select 3.
- Simultaneous stall and id_taken: no flush this cycle. The flush is issued in the cycle the stall drops.
- rst asserted mid-stall: slots clear immediately and hz_stall drops asynchronously with rst.
- Dependency on $0: never forwards, never stalls.
- Both operands hit: hz_fwda and hz_fwdb are resolved independently, and either one can trigger the stall.

## Test plan
- Reset then idle: hz_stall=0, hz_flush=0, hz_fwda=hz_fwdb=0, counters=0.
- ALU chain:
  - Cycle 1: add $3 (id_dest=3, wreg=1, m2reg=0).
  - Cycle 2: sub with rs=3, rt=3 → hz_fwda=hz_fwdb=1.
  - Cycle 3: instruction with rs=3 and no new producer → hz_fwda=2.
- Load-use:
  - lw $5, then a consumer with rs=5 → hz_stall=1 for 1 cycle, stall_cnt=1.
  - Next cycle the same consumer gets hz_fwda=3 and hz_stall=0.
- Priority: add $4 then lw $4, then a consumer with rt=4 → stall, then hz_fwdb=3. Checks that the youngest producer wins. Also: writes to $0 followed by consumers of rs=0 → selects 0, no stall.
- Branch:
  - id_taken=1 with no hazard → hz_flush=1, flush_cnt=1.
  - id_taken=1 with a load-use on rs → hz_flush=0 while stalled, hz_flush=1 in the following cycle.
- Counters: force 2^CNT_W+3 stall cycles → stall_cnt saturates at all-ones. Then cnt_clr=1 → both counters read 0 after one edge.

Source files
------------

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: ID-stage hazard unit for the five-stage MIPS core.
// A two-slot scoreboard (EX, MEM) records the destinations of in-flight
// producers. From it the block derives operand forwarding selects, the
// load-use stall and the taken-branch flush, and it counts stall/flush cycles.
//
// Handshake note: there is no valid/ready pairing here. Every ID input is
// taken to be valid in every cycle, and every output is a level that the
// pipeline consumes in the same cycle. hz_stall acts as the only
// back-pressure: while it is high the ID instruction is not accepted into EX.
module hazard_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [4:0]       id_dest,
  input  logic             id_taken,
  input  logic             cnt_clr,
  output logic             hz_stall,
  output logic             hz_flush,
  output logic [1:0]       hz_fwda,
  output logic [1:0]       hz_fwdb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Forward select encoding as seen by the ID operand muxes.
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXALU = 2'd1;
  localparam logic [1:0] FWD_MMALU = 2'd2;
  localparam logic [1:0] FWD_MMDAT = 2'd3;

  // Scoreboard slots. WB is not tracked: the register file is write-first.
  logic       ex_valid_q,  ex_valid_d;
  logic [4:0] ex_dest_q,   ex_dest_d;
  logic       ex_m2reg_q,  ex_m2reg_d;
  logic       mem_valid_q;
  logic [4:0] mem_dest_q;
  logic       mem_m2reg_q;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic m_ex_rs, m_mem_rs, m_ex_rt, m_mem_rt;
  logic [1:0] sel_a, sel_b;

  // Pick the youngest producer: EX ALU beats MEM, MEM ALU and MEM load are exclusive.
  function automatic logic [1:0] pick_fwd(input logic m_ex, input logic m_mem,
                                          input logic ex_ld, input logic mem_ld);
    logic [1:0] sel;
    sel = FWD_RF;
    if (m_ex && !ex_ld)        sel = FWD_EXALU;
    else if (m_mem && !mem_ld) sel = FWD_MMALU;
    else if (m_mem && mem_ld)  sel = FWD_MMDAT;
    return sel;
  endfunction

  // Source matching; reads of $0 and unused fields never match.
  always_comb begin
    m_ex_rs  = id_use_rs && (id_rs != 5'd0) && ex_valid_q  && (ex_dest_q  == id_rs);
    m_mem_rs = id_use_rs && (id_rs != 5'd0) && mem_valid_q && (mem_dest_q == id_rs);
    m_ex_rt  = id_use_rt && (id_rt != 5'd0) && ex_valid_q  && (ex_dest_q  == id_rt);
    m_mem_rt = id_use_rt && (id_rt != 5'd0) && mem_valid_q && (mem_dest_q == id_rt);
  end

  // Stall, flush and forward selects; selects are zeroed while stalled.
  always_comb begin
    sel_a    = pick_fwd(m_ex_rs, m_mem_rs, ex_m2reg_q, mem_m2reg_q);
    sel_b    = pick_fwd(m_ex_rt, m_mem_rt, ex_m2reg_q, mem_m2reg_q);
    hz_stall = (m_ex_rs || m_ex_rt) && ex_m2reg_q;
    hz_flush = id_taken && !hz_stall;
    hz_fwda  = hz_stall ? FWD_RF : sel_a;
    hz_fwdb  = hz_stall ? FWD_RF : sel_b;
  end

  // Next EX slot: the ID instruction, or a bubble when it is held back.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_dest_d  = 5'd0;
    ex_m2reg_d = 1'b0;
    if (!hz_stall) begin
      ex_valid_d = id_wreg && (id_dest != 5'd0);
      ex_dest_d  = id_dest;
      ex_m2reg_d = id_m2reg;
    end
  end

  // Scoreboard advance: ID -> EX -> MEM every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_dest_q   <= 5'd0;
      ex_m2reg_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dest_q  <= 5'd0;
      mem_m2reg_q <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_dest_q   <= ex_dest_d;
      ex_m2reg_q  <= ex_m2reg_d;
      mem_valid_q <= ex_valid_q;
      mem_dest_q  <= ex_dest_q;
      mem_m2reg_q <= ex_m2reg_q;
    end
  end

  // Saturating event counters; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (hz_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
      if (hz_flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler. Inputs change 1ns after the rising
// edge; combinational outputs and counters are sampled on the falling edge.
module tb_hazard_scheduler;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [4:0]    id_rs, id_rt, id_dest;
  logic          id_use_rs, id_use_rt, id_wreg, id_m2reg, id_taken, cnt_clr;
  logic          hz_stall, hz_flush;
  logic [1:0]    hz_fwda, hz_fwdb;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks;
  int n_pass;

  hazard_scheduler #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_wreg   (id_wreg),
    .id_m2reg  (id_m2reg),
    .id_dest   (id_dest),
    .id_taken  (id_taken),
    .cnt_clr   (cnt_clr),
    .hz_stall  (hz_stall),
    .hz_flush  (hz_flush),
    .hz_fwda   (hz_fwda),
    .hz_fwdb   (hz_fwdb),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Driver: apply one ID instruction, then wait for the sampling point.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic wreg, input logic m2reg,
                       input logic [4:0] dest, input logic taken);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wreg = wreg; id_m2reg = m2reg; id_dest = dest; id_taken = taken;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic st, input logic fl,
                            input logic [1:0] fa, input logic [1:0] fb);
    check({tag, ".stall"}, hz_stall, st);
    check({tag, ".flush"}, hz_flush, fl);
    check({tag, ".fwda"},  hz_fwda,  fa);
    check({tag, ".fwdb"},  hz_fwdb,  fb);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    cnt_clr  = 1'b0;
    id_rs = '0; id_rt = '0; id_dest = '0;
    id_use_rs = 0; id_use_rt = 0; id_wreg = 0; id_m2reg = 0; id_taken = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    idle();
    check_outs("reset", 0, 0, 0, 0);
    check("reset.stall_cnt", stall_cnt, 0);
    check("reset.flush_cnt", flush_cnt, 0);
    tick();

    // ALU chain: add $3; sub $7,$3,$3; use $3
    drive(5'd0, 5'd0, 0, 0, 1, 0, 5'd3, 0);
    check_outs("alu.c1", 0, 0, 0, 0);
    tick();
    drive(5'd3, 5'd3, 1, 1, 1, 0, 5'd7, 0);
    check_outs("alu.c2", 0, 0, 1, 1);
    tick();
    drive(5'd3, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    check_outs("alu.c3", 0, 0, 2, 0);
    tick();

    // Load-use: lw $5 ($0 base); consumer of $5 stalls once, then selects 3
    drive(5'd0, 5'd0, 1, 0, 1, 1, 5'd5, 0);
    check_outs("lu.load", 0, 0, 0, 0);
    tick();
    drive(5'd5, 5'd0, 1, 0, 1, 0, 5'd8, 0);
    check_outs("lu.stall", 1, 0, 0, 0);
    tick();
    drive(5'd5, 5'd0, 1, 0, 1, 0, 5'd8, 0);
    check_outs("lu.fwd", 0, 0, 3, 0);
    check("lu.stall_cnt", stall_cnt, 1);
    tick();

    // Priority: add $4; lw $4; consumer on rt=4 sees the load
    drive(5'd0, 5'd0, 0, 0, 1, 0, 5'd4, 0);
    tick();
    drive(5'd0, 5'd0, 0, 0, 1, 1, 5'd4, 0);
    tick();
    drive(5'd0, 5'd4, 0, 1, 0, 0, 5'd0, 0);
    check_outs("prio.stall", 1, 0, 0, 0);
    tick();
    drive(5'd0, 5'd4, 0, 1, 0, 0, 5'd0, 0);
    check_outs("prio.fwd", 0, 0, 0, 3);
    check("prio.stall_cnt", stall_cnt, 2);
    tick();

    // Writes to $0 never forward or stall
    drive(5'd0, 5'd0, 0, 0, 1, 1, 5'd0, 0);
    tick();
    drive(5'd0, 5'd0, 1, 1, 1, 0, 5'd0, 0);
    check_outs("zero.c1", 0, 0, 0, 0);
    tick();
    drive(5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 0);
    check_outs("zero.c2", 0, 0, 0, 0);
    tick();

    // Both operands hit: rs from EX ALU, rt from MEM load
    drive(5'd0, 5'd0, 0, 0, 1, 1, 5'd10, 0);
    tick();
    drive(5'd0, 5'd0, 0, 0, 1, 0, 5'd9, 0);
    tick();
    drive(5'd9, 5'd10, 1, 1, 0, 0, 5'd0, 0);
    check_outs("both", 0, 0, 1, 3);
    tick();

    // Branch with no hazard
    drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1);
    check_outs("br.plain", 0, 1, 0, 0);
    tick();
    drive(5'd0, 5'd0, 0, 0, 1, 1, 5'd11, 0);
    check("br.flush_cnt", flush_cnt, 1);
    tick();
    // Branch waiting on a load: flush deferred to the cycle the stall drops
    drive(5'd11, 5'd0, 1, 0, 0, 0, 5'd0, 1);
    check_outs("br.stalled", 1, 0, 0, 0);
    tick();
    drive(5'd11, 5'd0, 1, 0, 0, 0, 5'd0, 1);
    check_outs("br.release", 0, 1, 3, 0);
    check("br.stall_cnt", stall_cnt, 3);
    tick();
    idle();
    check("br.flush_cnt2", flush_cnt, 2);
    tick();

    // Reset asserted mid-stall
    drive(5'd0, 5'd0, 0, 0, 1, 1, 5'd12, 0);
    tick();
    drive(5'd12, 5'd0, 1, 0, 0, 0, 5'd0, 0);
    check("rst.pre_stall", hz_stall, 1);
    rst = 1'b1;
    #1;
    check("rst.stall_drop", hz_stall, 0);
    check("rst.stall_cnt", stall_cnt, 0);
    check("rst.flush_cnt", flush_cnt, 0);
    #1 rst = 1'b0;
    tick();

    // Saturation: 2^CW+3 stall cycles, each as load / stalled use / forwarded use
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      drive(5'd0, 5'd0, 0, 0, 1, 1, 5'd5, 0);
      tick();
      drive(5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
      tick();
      drive(5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0);
      tick();
      if (i == (1 << CW) - 2) check("sat.pre", stall_cnt, (1 << CW) - 1);
    end
    idle();
    check("sat.stall_cnt", stall_cnt, (1 << CW) - 1);
    tick();
    drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1);
    tick();
    idle();
    check("sat.flush_cnt", flush_cnt, 1);

    // Clear has priority over a coincident flush increment
    cnt_clr = 1'b1;
    drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1);
    tick();
    cnt_clr = 1'b0;
    idle();
    check("clr.stall_cnt", stall_cnt, 0);
    check("clr.flush_cnt", flush_cnt, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
